sram_serial_host: RTL and testbench

Hardware sequencer that drives the serial side of `SRAM_IO_CTRL` (SI, LOAD_N, CTRL, BGN; RDY/SO back) so on-chip logic can write or read one RA1SHD 512x8 byte through a simple parallel request port. It sits directly upstream of `SRAM_IO_CTRL`. It performs in RTL the bit-serial load, command and unload sequence that the block bench performs.

---
 rtl/sram_serial_host.sv | 179 +++++++++++++++++
 tb/tb_sram_serial_host.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_serial_host.sv
// Parallel request port that sequences the bit-serial load / command / unload
// protocol of SRAM_IO_CTRL to write or read a single SRAM byte.
module sram_serial_host #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ,
    input  logic              WR,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] RDATA,
    output logic              ERR,
    output logic              BGN,
    output logic              SI,
    output logic              LOAD_N,
    output logic [1:0]        CTRL,
    input  logic              RDY,
    input  logic              SO
);

    localparam int unsigned NXFER = DATA_W + ADDR_W + 1;
    localparam int unsigned XW    = $clog2(NXFER + 1);
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_RELEASE, S_FINISH} state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     xfer_q, xfer_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              bgn_q, bgn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              si_q, si_d;
    logic              load_n_q, load_n_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              in_xfer;

    always_comb begin
        state_d  = state_q;
        xfer_d   = xfer_q;
        tmo_d    = tmo_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    state_d = S_SETUP;
                    xfer_d  = '0;
                    wr_d    = WR;
                    addr_d  = ADDR;
                    wdata_d = WDATA;
                    err_d   = 1'b0;
                end
            end
            S_SETUP: begin
                state_d = S_PULSE;
                tmo_d   = '0;
                // Read unload transfers follow the address shifts and the command.
                for (int unsigned k = 0; k < DATA_W; k++) begin
                    if (!wr_q && xfer_q == XW'(ADDR_W + 1 + k)) shadow_d[k] = SO;
                end
            end
            S_PULSE: begin
                if (RDY) begin
                    state_d = S_RELEASE;
                    tmo_d   = '0;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_FINISH;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!RDY) begin
                    tmo_d = '0;
                    if (xfer_q == XW'(NXFER - 1)) begin
                        state_d = S_FINISH;
                        if (!wr_q) rdata_d = shadow_q;
                    end else begin
                        state_d = S_SETUP;
                        xfer_d  = xfer_q + 1'b1;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_FINISH;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from next-state values so every pin comes straight from a flop.
    always_comb begin
        in_xfer  = (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_RELEASE);
        bgn_d    = 1'b1;
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_FINISH);
        load_n_d = (state_d != S_PULSE);
        si_d     = 1'b0;
        ctrl_d   = 2'b00;
        if (in_xfer) begin
            for (int unsigned k = 0; k < DATA_W; k++) begin
                if (wr_d && xfer_d == XW'(k)) si_d = wdata_d[k];
            end
            for (int unsigned k = 0; k < ADDR_W; k++) begin
                if (wr_d && xfer_d == XW'(DATA_W + k)) si_d = addr_d[k];
                if (!wr_d && xfer_d == XW'(k)) si_d = addr_d[k];
            end
            if (wr_d && xfer_d == XW'(NXFER - 1)) ctrl_d = 2'b11;
            if (!wr_d && xfer_d == XW'(ADDR_W)) ctrl_d = 2'b01;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            xfer_q   <= '0;
            tmo_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            shadow_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            bgn_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            si_q     <= 1'b0;
            load_n_q <= 1'b1;
            ctrl_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            xfer_q   <= xfer_d;
            tmo_q    <= tmo_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            bgn_q    <= bgn_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            si_q     <= si_d;
            load_n_q <= load_n_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RDATA  = rdata_q;
    assign ERR    = err_q;
    assign BGN    = bgn_q;
    assign SI     = si_q;
    assign LOAD_N = load_n_q;
    assign CTRL   = ctrl_q;

endmodule

// File: tb/tb_sram_serial_host.sv
// Bench for sram_serial_host: a behavioural SRAM_IO_CTRL stand-in answers the
// serial side, and a DONE-triggered scoreboard checks each transaction.
module tb_sram_serial_host;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       REQ = 1'b0;
    logic       WR = 1'b0;
    logic [8:0] ADDR = '0;
    logic [7:0] WDATA = '0;
    logic       BUSY, DONE, ERR, BGN, SI, LOAD_N;
    logic [7:0] RDATA;
    logic [1:0] CTRL;
    logic       RDY = 1'b0;
    logic       SO = 1'b0;

    sram_serial_host #(.ADDR_W(9), .DATA_W(8), .TIMEOUT(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WR(WR), .ADDR(ADDR), .WDATA(WDATA),
        .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA), .ERR(ERR), .BGN(BGN), .SI(SI),
        .LOAD_N(LOAD_N), .CTRL(CTRL), .RDY(RDY), .SO(SO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit       wr;
        bit [8:0] addr;
        bit [7:0] wdata;
        bit [7:0] exp_rdata;
        bit       exp_err;
        bit       chk_cyc;
    } ent_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    logic [7:0] ref_mem[512];
    logic [7:0] dev_mem[512];
    logic [7:0] ref_rdata = '0;

    bit         stuck = 0;
    bit         jit_en = 0;
    int         jit = 0;
    int         lo_cnt = 0, hi_cnt = 0, last_lo_run = 0;
    int         fall_cnt = 0, busy_cyc = 0;
    bit         busy_prev = 0, prev_load_n = 1;
    logic [31:0] shreg = '0;
    int         nbits = 0, wr_nbits = 0, rd_nbits = 0;
    logic [31:0] wr_word = '0;
    logic [8:0] rd_addr = '0;
    logic [7:0] rbyte = '0;
    logic [3:0] uk = '0;
    bit         unloading = 0, wr_cmd_seen = 0, rd_cmd_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // SRAM_IO_CTRL stand-in and scoreboard monitor, both evaluated on the falling edge.
    always @(negedge CLK) begin
        if (!RST_N) begin
            RDY = 1'b0; SO = 1'b0; lo_cnt = 0; hi_cnt = 0; fall_cnt = 0;
            busy_prev = 0; busy_cyc = 0; unloading = 0; prev_load_n = 1;
        end else begin
            if (BUSY && !busy_prev) begin
                fall_cnt = 0; shreg = '0; nbits = 0; unloading = 0;
                wr_cmd_seen = 0; rd_cmd_seen = 0;
            end
            busy_prev = BUSY;
            busy_cyc  = BUSY ? busy_cyc + 1 : 0;
            if (!LOAD_N) begin
                if (prev_load_n) begin
                    fall_cnt++;
                    lo_cnt = 0;
                    jit = jit_en ? int'($urandom_range(0, 3)) : 0;
                    case (CTRL)
                        2'b00: begin
                            if (unloading) begin
                                uk = uk + 4'd1;
                                SO = (uk < 4'd8) ? rbyte[uk[2:0]] : 1'b0;
                            end else begin
                                shreg = shreg | (32'(SI) << nbits);
                                nbits++;
                            end
                        end
                        2'b11: begin
                            wr_word = shreg; wr_nbits = nbits; wr_cmd_seen = 1;
                            dev_mem[shreg[16:8]] = shreg[7:0];
                        end
                        2'b01: begin
                            rd_addr = shreg[8:0]; rd_nbits = nbits; rd_cmd_seen = 1;
                            rbyte = dev_mem[rd_addr]; unloading = 1; uk = '0;
                            SO = rbyte[0];
                        end
                        default: ;
                    endcase
                end
                lo_cnt++;
                if (!stuck && lo_cnt >= 2 + jit) RDY = 1'b1;
            end else begin
                if (!prev_load_n) begin
                    last_lo_run = lo_cnt;
                    hi_cnt = 0;
                    jit = jit_en ? int'($urandom_range(0, 3)) : 0;
                end
                hi_cnt++;
                if (hi_cnt >= 2 + jit) RDY = 1'b0;
            end
            prev_load_n = LOAD_N;

            if (DONE) begin
                chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    ent_t e;
                    e = sb.pop_front();
                    chk("busy_at_done", 32'(BUSY), 32'd1);
                    chk("load_n_at_done", 32'(LOAD_N), 32'd1);
                    chk("ctrl_at_done", 32'(CTRL), 32'd0);
                    chk("err", 32'(ERR), 32'(e.exp_err));
                    chk("rdata", 32'(RDATA), 32'(e.exp_rdata));
                    chk("load_n_falls", 32'(fall_cnt), e.exp_err ? 32'd1 : 32'd18);
                    if (e.chk_cyc) chk("txn_cycles", 32'(busy_cyc), 32'd91);
                    if (e.exp_err) begin
                        chk("tmo_low_cycles", 32'(last_lo_run), 32'd16);
                    end else if (e.wr) begin
                        chk("wr_cmd", 32'(wr_cmd_seen), 32'd1);
                        chk("wr_shift_bits", 32'(wr_nbits), 32'd17);
                        chk("wr_word", wr_word, 32'({e.addr, e.wdata}));
                    end else begin
                        chk("rd_cmd", 32'(rd_cmd_seen), 32'd1);
                        chk("rd_shift_bits", 32'(rd_nbits), 32'd9);
                        chk("rd_addr", 32'(rd_addr), 32'(e.addr));
                    end
                end
                done_cnt++;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 400) begin @(negedge CLK); n++; end
        if (BUSY) chk("idle_wait", 32'(BUSY), 32'd0);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 400) begin @(negedge CLK); n++; end
        if (done_cnt < target) chk("done_wait", 32'(done_cnt), 32'(target));
    endtask

    task automatic issue(input bit wr, input bit [8:0] a, input bit [7:0] d,
                         input bit tmo, input bit cyc);
        ent_t e;
        wait_idle();
        @(negedge CLK);
        REQ = 1'b1; WR = wr; ADDR = a; WDATA = d;
        if (!tmo) begin
            if (wr) ref_mem[a] = d;
            else    ref_rdata = ref_mem[a];
        end
        e.wr = wr; e.addr = a; e.wdata = d; e.exp_err = tmo; e.chk_cyc = cyc;
        e.exp_rdata = ref_rdata;
        sb.push_back(e);
        @(posedge CLK); #1;
        REQ = 1'b0;
        chk("busy_rise", 32'(BUSY), 32'd1);
        chk("err_clear", 32'(ERR), 32'd0);
    endtask

    task automatic run(input bit wr, input bit [8:0] a, input bit [7:0] d,
                       input bit tmo, input bit cyc);
        int tgt;
        tgt = done_cnt + 1;
        issue(wr, a, d, tmo, cyc);
        wait_done(tgt);
    endtask

    initial begin
        int tgt, n;
        ent_t e;
        for (int i = 0; i < 512; i++) begin ref_mem[i] = '0; dev_mem[i] = '0; end

        repeat (3) @(negedge CLK);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_rdata", 32'(RDATA), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_bgn", 32'(BGN), 32'd0);
        chk("rst_si", 32'(SI), 32'd0);
        chk("rst_load_n", 32'(LOAD_N), 32'd1);
        chk("rst_ctrl", 32'(CTRL), 32'd0);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("bgn_rise", 32'(BGN), 32'd1);

        run(1, 9'h020, 8'h0C, 0, 1);
        run(1, 9'h021, 8'hA5, 0, 1);
        run(0, 9'h021, 8'h00, 0, 1);
        for (int a = 'h20; a <= 'h2D; a++) run(1, 9'(a), 8'($urandom), 0, 1);
        for (int a = 'h20; a <= 'h2D; a++) run(0, 9'(a), 8'h00, 0, 1);

        // RDY never answers: expect timeout, then the next request clears ERR.
        stuck = 1;
        run(1, 9'h040, 8'h3C, 1, 0);
        stuck = 0;
        run(0, 9'h021, 8'h00, 0, 1);
        stuck = 1;
        run(0, 9'h020, 8'h00, 1, 0);
        stuck = 0;

        // Reset pulse during the fifth transfer of a write.
        wait_idle();
        @(negedge CLK);
        REQ = 1'b1; WR = 1'b1; ADDR = 9'h055; WDATA = 8'h77;
        e.wr = 1; e.addr = 9'h055; e.wdata = 8'h77; e.exp_err = 0; e.chk_cyc = 0;
        e.exp_rdata = ref_rdata;
        sb.push_back(e);
        @(posedge CLK); #1;
        REQ = 1'b0;
        n = 0;
        while (fall_cnt != 5 && n < 100) begin @(negedge CLK); n++; end
        if (fall_cnt != 5) chk("fifth_xfer_wait", 32'(fall_cnt), 32'd5);
        #2 RST_N = 1'b0;
        #1;
        chk("rst_mid_load_n", 32'(LOAD_N), 32'd1);
        chk("rst_mid_ctrl", 32'(CTRL), 32'd0);
        chk("rst_mid_busy", 32'(BUSY), 32'd0);
        chk("rst_mid_bgn", 32'(BGN), 32'd0);
        void'(sb.pop_back());
        ref_rdata = '0;
        @(negedge CLK); @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("rst_mid_bgn_back", 32'(BGN), 32'd1);
        run(1, 9'h055, 8'h77, 0, 1);
        run(0, 9'h055, 8'h00, 0, 1);

        // REQ held high through a read: exactly one back-to-back repeat, only after DONE.
        wait_idle();
        tgt = done_cnt;
        @(negedge CLK);
        REQ = 1'b1; WR = 1'b0; ADDR = 9'h023;
        ref_rdata = ref_mem[9'h023];
        e.wr = 0; e.addr = 9'h023; e.wdata = 0; e.exp_err = 0; e.chk_cyc = 1;
        e.exp_rdata = ref_rdata;
        sb.push_back(e);
        sb.push_back(e);
        wait_done(tgt + 1);
        n = 0;
        while (BUSY && n < 10) begin @(negedge CLK); n++; end
        n = 0;
        while (!BUSY && n < 10) begin @(negedge CLK); n++; end
        REQ = 1'b0;
        chk("held_req_restart", 32'(BUSY), 32'd1);
        wait_done(tgt + 2);
        repeat (10) @(negedge CLK);
        chk("held_req_no_third", 32'(BUSY), 32'd0);
        chk("held_req_txns", 32'(done_cnt), 32'(tgt + 2));

        // Random traffic with variable RDY latency.
        jit_en = 1;
        for (int i = 0; i < 24; i++) begin
            bit w;
            w = ($urandom_range(0, 1) == 1);
            run(w, 9'($urandom_range(0, 511) & 32'h3F), 8'($urandom), 0, 0);
        end
        jit_en = 0;

        repeat (5) @(negedge CLK);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
